// File: rtl/gesture_vote_filter.sv
// Temporal majority-vote filter: sliding window of per-frame classes, one emit pulse per
// dominant gesture, followed by a frame-counted refractory holdoff and a stale-history flush.
module gesture_vote_filter #(
    parameter int unsigned NUM_CLASSES    = 4,
    parameter int unsigned HIST_DEPTH     = 8,
    parameter int unsigned VOTE_THRESH    = 5,
    parameter logic [7:0]  CONF_THRESH    = 8'd64,
    parameter int unsigned HOLDOFF_FRAMES = 20,
    parameter int unsigned STALE_CYCLES   = 360000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [$clog2(NUM_CLASSES)-1:0]    in_class,
    input  logic                              in_valid,
    input  logic [7:0]                        in_confidence,
    output logic [$clog2(NUM_CLASSES)-1:0]    out_class,
    output logic                              out_valid,
    output logic [7:0]                        out_confidence,
    output logic [$clog2(HIST_DEPTH+1)-1:0]   out_votes,
    output logic                              armed
);

    localparam int unsigned CW = $clog2(NUM_CLASSES);
    localparam int unsigned VW = $clog2(HIST_DEPTH + 1);
    localparam int unsigned PW = $clog2(HIST_DEPTH);
    localparam int unsigned HW = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
    localparam int unsigned SW = $clog2(STALE_CYCLES + 1);

    typedef enum logic {ST_ARMED, ST_HOLDOFF} state_t;

    state_t          state_q;
    logic            armed_q;
    logic            hist_vld_q [HIST_DEPTH];
    logic [CW-1:0]   hist_cls_q [HIST_DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [VW-1:0]   cnt_q      [NUM_CLASSES];
    logic [VW-1:0]   cnt_d      [NUM_CLASSES];
    logic [HW-1:0]   hold_q;
    logic [SW-1:0]   stale_q;
    logic            eval_pend_q;
    logic            eval_ok_q;
    logic [7:0]      conf_q;
    logic [CW-1:0]   out_class_q;
    logic            out_valid_q;
    logic [7:0]      out_conf_q;
    logic [VW-1:0]   out_votes_q;

    logic            new_vld_c;
    logic            ev_vld_c;
    logic [CW-1:0]   ev_cls_c;
    logic [CW-1:0]   best_cls_c;
    logic [VW-1:0]   best_cnt_c;
    logic            emit_c;
    logic            stale_hit_c;
    logic            flush_c;
    logic            push_c;

    // Incremental vote update for a push, and argmax (lowest index wins ties)
    always_comb begin
        new_vld_c = (in_confidence >= CONF_THRESH);
        ev_vld_c  = hist_vld_q[wr_ptr_q];
        ev_cls_c  = hist_cls_q[wr_ptr_q];
        for (int c = 0; c < NUM_CLASSES; c++) begin
            cnt_d[c] = cnt_q[c]
                     - VW'(ev_vld_c && (ev_cls_c == CW'(c)))
                     + VW'(new_vld_c && (in_class == CW'(c)));
        end
        best_cls_c = '0;
        best_cnt_c = cnt_q[0];
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (cnt_q[c] > best_cnt_c) begin
                best_cls_c = CW'(c);
                best_cnt_c = cnt_q[c];
            end
        end
        emit_c      = eval_pend_q && eval_ok_q && (best_cnt_c >= VW'(VOTE_THRESH));
        stale_hit_c = !in_valid && (stale_q == SW'(STALE_CYCLES - 1));
        // An emit flush drops a frame arriving on the same edge
        flush_c     = emit_c || stale_hit_c;
        push_c      = in_valid && !emit_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARMED;
            armed_q     <= 1'b1;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_vld_q[i] <= 1'b0;
                hist_cls_q[i] <= '0;
            end
            for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= '0;
            wr_ptr_q    <= '0;
            hold_q      <= '0;
            stale_q     <= '0;
            eval_pend_q <= 1'b0;
            eval_ok_q   <= 1'b0;
            conf_q      <= '0;
            out_class_q <= '0;
            out_valid_q <= 1'b0;
            out_conf_q  <= '0;
            out_votes_q <= '0;
        end else begin
            out_valid_q <= 1'b0;
            eval_pend_q <= push_c;
            if (push_c) begin
                eval_ok_q <= (state_q == ST_ARMED);
                conf_q    <= in_confidence;
            end

            if (emit_c) begin
                out_valid_q <= 1'b1;
                out_class_q <= best_cls_c;
                out_votes_q <= best_cnt_c;
                out_conf_q  <= conf_q;
            end

            if (flush_c) begin
                for (int i = 0; i < HIST_DEPTH; i++) hist_vld_q[i] <= 1'b0;
                for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= '0;
                wr_ptr_q <= '0;
            end else if (push_c) begin
                hist_vld_q[wr_ptr_q] <= new_vld_c;
                hist_cls_q[wr_ptr_q] <= in_class;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
                cnt_q                <= cnt_d;
            end

            // Saturating idle counter; any strobe (even a dropped one) restarts it
            if (in_valid) begin
                stale_q <= '0;
            end else if (stale_q != SW'(STALE_CYCLES)) begin
                stale_q <= stale_q + SW'(1);
            end

            case (state_q)
                ST_ARMED: begin
                    if (emit_c && (HOLDOFF_FRAMES > 0)) begin
                        state_q <= ST_HOLDOFF;
                        armed_q <= 1'b0;
                        hold_q  <= HW'(HOLDOFF_FRAMES);
                    end
                end
                ST_HOLDOFF: begin
                    if (push_c) begin
                        hold_q <= hold_q - HW'(1);
                        if (hold_q == HW'(1)) begin
                            state_q <= ST_ARMED;
                            armed_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_ARMED;
                    armed_q <= 1'b1;
                end
            endcase
        end
    end

    assign out_class      = out_class_q;
    assign out_valid      = out_valid_q;
    assign out_confidence = out_conf_q;
    assign out_votes      = out_votes_q;
    assign armed          = armed_q;

endmodule
